// File: rtl/video_pkg.sv
// Shared pixel type, default 682x524 NTSC-doubled raster timing and pixel helpers
// for the scaled video output stage.
package video_pkg;

  typedef struct packed {
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } rgb555_t;

  localparam int DEF_SRC_W    = 256;
  localparam int DEF_SCALE    = 2;
  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_H_FP     = 58;
  localparam int DEF_H_SYNC   = 82;
  localparam int DEF_H_BP     = 30;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 32;
  localparam int DEF_H_TOT    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOT    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  function automatic int scale_sh(input int scale);
    return $clog2(scale);
  endfunction

  localparam int DEF_SCALE_SH = scale_sh(DEF_SCALE);

  // Halve every channel; used for the darker line of each replicated group.
  function automatic rgb555_t dim555(input rgb555_t p);
    rgb555_t o;
    o.b = p.b >> 1;
    o.g = p.g >> 1;
    o.r = p.r >> 1;
    return o;
  endfunction

endpackage

// File: rtl/video_scaler_gen_if.sv
// Source pixel stream, display controls and scaled video outputs of the scaler.
// slave = scaler side, master = palette stage / display sink side.
interface video_scaler_gen_if
  import video_pkg::*;
#(
  parameter int OUT_W = 4
);
  rgb555_t          src_pixel;
  logic             src_valid;
  logic             src_sol;
  logic             src_sof;
  logic             overscan;
  logic             scanlines;
  logic             hs;
  logic             vs;
  logic             de;
  logic [OUT_W-1:0] r;
  logic [OUT_W-1:0] g;
  logic [OUT_W-1:0] b;
  logic             locked;
  logic             ovf;

  modport master (
    output src_pixel, src_valid, src_sol, src_sof, overscan, scanlines,
    input  hs, vs, de, r, g, b, locked, ovf
  );

  modport slave (
    input  src_pixel, src_valid, src_sol, src_sof, overscan, scanlines,
    output hs, vs, de, r, g, b, locked, ovf
  );
endinterface

// File: rtl/line_buf_2bank.sv
// Two-bank source line store, bank is the address MSB; synchronous write, registered
// read (1 cycle). No flow control: every write/read is accepted each cycle.
module line_buf_2bank
  import video_pkg::*;
#(
  parameter int  SRC_W = DEF_SRC_W,
  localparam int AW    = $clog2(SRC_W)
) (
  input  logic    clk,
  input  logic    i_wr_en,
  input  logic    [AW:0] i_wr_addr,
  input  rgb555_t i_wr_dat,
  input  logic    [AW:0] i_rd_addr,
  output rgb555_t o_rd_dat
);

  rgb555_t r_mem [0:(2**(AW+1))-1];
  rgb555_t r_rd_dat;

  // No reset so the array and its read register map onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
    r_rd_dat <= r_mem[i_rd_addr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/video_scaler_gen.sv
// Scaled raster generator: ping-pong line buffer, pixel/line replication, overscan mask;
// 2-cycle counter-to-output latency, no source backpressure. Dimming under VIDEO_SCANLINE_EN.
module video_scaler_gen
  import video_pkg::*;
#(
  parameter int SRC_W    = DEF_SRC_W,
  parameter int SCALE    = DEF_SCALE,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int OUT_W    = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int OS_L     = 20,
  parameter int OS_R     = 16,
  parameter int OS_T     = 12,
  parameter int OS_B     = 20
) (
  input logic               clk,
  input logic               rst_n,
  video_scaler_gen_if.slave io_vid
);

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOT);
  localparam int VW       = $clog2(V_TOT);
  localparam int RW       = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int AW       = $clog2(SRC_W);
  localparam int WAW      = $clog2(SRC_W + 1);
  localparam int SCALE_SH = scale_sh(SCALE);

  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOT - 1);
  localparam logic [RW-1:0]  REP_LAST = RW'(SCALE - 1);
  localparam logic [HW-1:0]  H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [VW-1:0]  V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [HW-1:0]  HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0]  H_OSL_C  = HW'(OS_L);
  localparam logic [HW-1:0]  H_OSR_C  = HW'(H_ACTIVE - OS_R);
  localparam logic [VW-1:0]  V_OST_C  = VW'(OS_T);
  localparam logic [VW-1:0]  V_OSB_C  = VW'(V_ACTIVE - OS_B);
  localparam logic [WAW-1:0] SRC_WC   = WAW'(SRC_W);

  logic [HW-1:0]    r_h;
  logic [VW-1:0]    r_v;
  logic [RW-1:0]    r_rep;
  logic             r_wr_bank;
  logic [WAW-1:0]   r_wr_addr;
  logic             r_rd_bank;
  logic             w_rd_bank;
  logic             r_locked;
  logic             r_ovf;
  logic             w_wr_en;
  logic [AW:0]      w_wr_addr;
  logic [AW:0]      w_rd_addr;
  logic             w_de_raw;
  logic             w_hs_raw;
  logic             w_vs_raw;
  logic             w_mask_raw;
  logic             r_de_s1;
  logic             r_hs_s1;
  logic             r_vs_s1;
  logic             r_mask_s1;
  rgb555_t          w_rd_dat;
  rgb555_t          w_pix;
  logic             w_show;
  logic             r_de;
  logic             r_hs;
  logic             r_vs;
  logic [OUT_W-1:0] r_r;
  logic [OUT_W-1:0] r_g;
  logic [OUT_W-1:0] r_b;

  // Raster counters; a source frame start overrides the natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h   <= '0;
      r_v   <= '0;
      r_rep <= '0;
    end else if (io_vid.src_sof) begin
      r_h   <= '0;
      r_v   <= '0;
      r_rep <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      if (r_v == V_LAST) begin
        r_v   <= '0;
        r_rep <= '0;
      end else begin
        r_v   <= r_v + 1'b1;
        r_rep <= (r_rep == REP_LAST) ? '0 : r_rep + 1'b1;
      end
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // A pixel arriving together with src_sol is the first pixel of the new line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_addr <= '0;
      r_ovf     <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      if (io_vid.src_sol) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_addr <= io_vid.src_valid ? WAW'(1) : '0;
      end else if (io_vid.src_valid) begin
        if (r_wr_addr == SRC_WC) begin
          r_ovf <= 1'b1;
        end else begin
          r_wr_addr <= r_wr_addr + 1'b1;
        end
      end
      if (io_vid.src_sof) begin
        r_locked <= 1'b1;
      end
    end
  end

  assign w_wr_en   = io_vid.src_valid && (io_vid.src_sol || (r_wr_addr != SRC_WC));
  assign w_wr_addr = io_vid.src_sol ? {~r_wr_bank, {AW{1'b0}}}
                                    : {r_wr_bank, r_wr_addr[AW-1:0]};

  // The bank switch is bypassed so pixel 0 of a new line group already reads the new bank.
  assign w_rd_bank = ((r_h == '0) && (r_rep == '0)) ? ~r_wr_bank : r_rd_bank;
  assign w_rd_addr = {w_rd_bank, (r_h < H_ACT_C) ? AW'(r_h >> SCALE_SH) : {AW{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank <= 1'b0;
    end else begin
      r_rd_bank <= w_rd_bank;
    end
  end

  line_buf_2bank #(
    .SRC_W (SRC_W)
  ) u_line_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_dat  (io_vid.src_pixel),
    .i_rd_addr (w_rd_addr),
    .o_rd_dat  (w_rd_dat)
  );

  assign w_de_raw   = (r_h < H_ACT_C) && (r_v < V_ACT_C);
  assign w_hs_raw   = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vs_raw   = (r_v >= VS_BEG) && (r_v < VS_END);
  assign w_mask_raw = io_vid.overscan &&
                      ((r_h < H_OSL_C) || (r_h >= H_OSR_C) ||
                       (r_v < V_OST_C) || (r_v >= V_OSB_C));

  // Stage 1 runs alongside the RAM read so controls line up with the read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_s1   <= 1'b0;
      r_hs_s1   <= 1'b0;
      r_vs_s1   <= 1'b0;
      r_mask_s1 <= 1'b0;
    end else begin
      r_de_s1   <= w_de_raw;
      r_hs_s1   <= w_hs_raw;
      r_vs_s1   <= w_vs_raw;
      r_mask_s1 <= w_mask_raw;
    end
  end

`ifdef VIDEO_SCANLINE_EN
  logic w_dim_raw;
  logic r_dim_s1;

  assign w_dim_raw = io_vid.scanlines && (SCALE > 1) && (r_rep == REP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dim_s1 <= 1'b0;
    end else begin
      r_dim_s1 <= w_dim_raw;
    end
  end

  assign w_pix = r_dim_s1 ? dim555(w_rd_dat) : w_rd_dat;
`else
  logic w_unused_scanlines;

  assign w_unused_scanlines = io_vid.scanlines;
  assign w_pix              = w_rd_dat;
`endif

  assign w_show = r_de_s1 && !r_mask_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de <= 1'b0;
      r_hs <= ~HS_POL;
      r_vs <= ~VS_POL;
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
    end else begin
      r_de <= r_de_s1;
      r_hs <= r_hs_s1 ? HS_POL : ~HS_POL;
      r_vs <= r_vs_s1 ? VS_POL : ~VS_POL;
      r_r  <= w_show ? w_pix.r[4 -: OUT_W] : '0;
      r_g  <= w_show ? w_pix.g[4 -: OUT_W] : '0;
      r_b  <= w_show ? w_pix.b[4 -: OUT_W] : '0;
    end
  end

  assign io_vid.de     = r_de;
  assign io_vid.hs     = r_hs;
  assign io_vid.vs     = r_vs;
  assign io_vid.r      = r_r;
  assign io_vid.g      = r_g;
  assign io_vid.b      = r_b;
  assign io_vid.locked = r_locked;
  assign io_vid.ovf    = r_ovf;

endmodule

// File: tb/tb_video_scaler_gen.sv
// Directed bench for video_scaler_gen: default horizontal timing, shortened vertical
// timing (36/2/2/2 lines) so whole frames fit in a short run.
module tb_video_scaler_gen;

  localparam int H_TOT = 682;
  localparam int V_TOT = 42;

`ifdef VIDEO_SCANLINE_EN
  localparam logic [12:0] DIM_EXP = 13'h1777;
`else
  localparam logic [12:0] DIM_EXP = 13'h1FFF;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pos = 0;
  int   hh;

  // Overscan probe points on line 12: {h, expected {de,r,g,b}} for the ramp line.
  int          os_h [6] = '{19, 20, 25, 495, 496, 512};
  logic [12:0] os_e [6] = '{13'h1000, 13'h1500, 13'h1600, 13'h1B30, 13'h1000, 13'h0000};

  always #5 clk = ~clk;

  video_scaler_gen_if #(.OUT_W(4)) vid ();

  video_scaler_gen #(
    .V_ACTIVE (36),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_vid (vid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic run_to(input int p);
    while (pos < p) tick();
  endtask

  task automatic sof_pulse();
    vid.src_sof = 1'b1;
    tick();
    vid.src_sof = 1'b0;
    pos = 0;
  endtask

  function automatic logic [12:0] vout();
    return {vid.de, vid.r, vid.g, vid.b};
  endfunction

  // Expected active pixel: top 4 bits of each 5-bit channel, de=1.
  function automatic logic [12:0] px(input logic [14:0] p);
    logic [4:0] cr, cg, cb;
    cr = p[4:0];
    cg = p[9:5];
    cb = p[14:10];
    return {1'b1, cr[4:1], cg[4:1], cb[4:1]};
  endfunction

  initial begin
    rst_n         = 1'b0;
    vid.src_pixel = '0;
    vid.src_valid = 1'b0;
    vid.src_sol   = 1'b0;
    vid.src_sof   = 1'b0;
    vid.overscan  = 1'b0;
    vid.scanlines = 1'b0;
    repeat (3) tick();
    check("rst_video", vout(), 13'h0);
    check("rst_sync", {vid.hs, vid.vs}, 2'b11);
    check("rst_flags", {vid.locked, vid.ovf}, 2'b00);
    rst_n = 1'b1;

    // Ramp line into bank 0, close it, then lock the raster.
    for (int i = 0; i < 256; i++) begin
      vid.src_valid = 1'b1;
      vid.src_pixel = 15'(i);
      tick();
    end
    vid.src_valid = 1'b0;
    vid.src_sol   = 1'b1;
    tick();
    vid.src_sol   = 1'b0;
    check("unlocked", vid.locked, 1'b0);
    sof_pulse();
    check("locked", vid.locked, 1'b1);

    run_to(2);
    for (int n = 0; n < 2 * H_TOT; n++) begin
      hh = n % H_TOT;
      if (hh < 520)
        check($sformatf("dbl_v%0d_h%0d", n / H_TOT, hh), vout(),
              (hh < 512) ? px(15'(hh >> 1)) : 13'h0);
      tick();
    end

    // Re-lock mid-frame at h=300, v=5; vs must first appear on line 38.
    run_to(5 * H_TOT + 300);
    sof_pulse();
    while (vid.vs !== 1'b0 && pos < 40000) tick();
    check("vs_first_line", pos, 38 * H_TOT + 2);

    // Frame start on the very last raster cycle, with the overscan mask on.
    run_to(V_TOT * H_TOT - 1);
    vid.src_sof  = 1'b1;
    vid.overscan = 1'b1;
    tick();
    vid.src_sof  = 1'b0;
    pos = 0;
    run_to(2);
    check("os_v0_h0", vout(), 13'h1000);
    for (int v = 1; v < 12; v++) begin
      run_to(v * H_TOT + 2 + 25);
      check($sformatf("os_v%0d_h25", v), vout(), 13'h1000);
    end
    for (int k = 0; k < 6; k++) begin
      run_to(12 * H_TOT + 2 + os_h[k]);
      check($sformatf("os_v12_h%0d", os_h[k]), vout(), os_e[k]);
    end

    // Overflow: 256 white pixels, then 4 black ones that must be dropped.
    vid.overscan = 1'b0;
    for (int i = 0; i < 256; i++) begin
      vid.src_valid = 1'b1;
      vid.src_pixel = 15'h7FFF;
      tick();
    end
    check("ovf_at_limit", vid.ovf, 1'b0);
    vid.src_pixel = 15'h0000;
    tick();
    check("ovf_set", vid.ovf, 1'b1);
    repeat (3) tick();
    vid.src_valid = 1'b0;
    vid.src_sol   = 1'b1;
    tick();
    vid.src_sol   = 1'b0;
    vid.scanlines = 1'b1;
    sof_pulse();
    run_to(2);
    check("ovf_line_h0", vout(), 13'h1FFF);
    run_to(2 + 511);
    check("ovf_line_h511", vout(), 13'h1FFF);
    run_to(H_TOT + 2);
    check("scan_rep1_h0", vout(), DIM_EXP);
    run_to(H_TOT + 2 + 511);
    check("scan_rep1_h511", vout(), DIM_EXP);
    run_to(2 * H_TOT + 2);
    check("scan_rep0_v2", vout(), 13'h1FFF);
    check("ovf_sticky", vid.ovf, 1'b1);

    // Reset in the middle of an active line.
    run_to(2 * H_TOT + 100);
    rst_n = 1'b0;
    #1;
    check("rst_mid_video", vout(), 13'h0);
    check("rst_mid_sync", {vid.hs, vid.vs}, 2'b11);
    check("rst_mid_flags", {vid.locked, vid.ovf}, 2'b00);
    repeat (5) tick();
    check("rst_hold_video", vout(), 13'h0);
    check("rst_hold_sync", {vid.hs, vid.vs}, 2'b11);
    rst_n = 1'b1;
    pos = 0;
    while (vid.hs !== 1'b0 && pos < 2000) begin
      tick();
      if (pos == 2) check("rst_first_px", vout(), 13'h1FFF);
    end
    check("hs_first_cycle", pos, 572);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_scaler_gen.md
# video_scaler_gen

Parametrised video output stage for the NES HDMI/VGA path. It accepts RGB555 pixels from the palette stage at source resolution and buffers each source line in a two-bank ping-pong line buffer. It generates programmable H/V raster timing and replicates each pixel and line by an integer factor, with an overscan mask and optional scanline dimming. It generalises the fixed 256→512 doubler with hard-coded 682×524 timing into configurable scale, timing, output depth and sync polarity, and adds a lock indicator and an overflow flag.

## Interface
- `SRC_W`, 256: source pixels per line.
- `SCALE`, 2: pixel/line replication factor; legal values are 1, 2, 4.
- `H_ACTIVE`, 512: active output pixels; must equal `SRC_W*SCALE`.
- `H_FP`, `H_SYNC`, `H_BP`, 58 / 82 / 30: horizontal porch and sync widths, in output pixels.
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`, 480 / 10 / 2 / 32: vertical timing, in output lines.
- `OUT_W`, 4: output bits per colour channel, 1..5; takes the MSBs of each 5-bit channel.
- `HS_POL`, `VS_POL`, 0: sync active level.
- `OS_L`, `OS_R`, `OS_T`, `OS_B`, 20 / 16 / 12 / 20: overscan mask margins, in output pixels/lines.
- `clk` in 1: pixel clock, and the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_pixel` in 15: RGB555 pixel, {B[14:10], G[9:5], R[4:0]}.
- `src_valid` in 1: `src_pixel` is valid this cycle.
- `src_sol` in 1: start of source line; single-cycle pulse.
- `src_sof` in 1: start of source frame; single-cycle pulse.
- `overscan` in 1: enables the overscan mask.
- `scanlines` in 1: enables scanline dimming.
- `hs`, `vs` out 1: syncs with polarity set by `HS_POL`/`VS_POL`.
- `de` out 1: active video.
- `r`, `g`, `b` out `OUT_W`: colour outputs.
- `locked` out 1: a `src_sof` has been seen since reset.
- `ovf` out 1: sticky flag; set when more than `SRC_W` valid pixels arrive in one line.

## Operation
- **Write side.** `wr_bank` toggles on `src_sol`, and `wr_addr` clears to 0. Each `src_valid` writes `src_pixel` to `[wr_bank][wr_addr]` and increments `wr_addr`, which saturates at `SRC_W`. A write at `wr_addr==SRC_W` is dropped and sets `ovf`.
- **Counters.** `h` counts 0..H_TOT-1, where `H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP`. `v` advances when `h==H_TOT-1` and counts 0..V_TOT-1. `rep` (0..SCALE-1) counts output lines within each source line and advances with `v`.
- **Frame lock.** `src_sof` forces `h=0`, `v=0`, `rep=0` on the next edge and sets `locked`. If `src_sof` and the counter wrap occur in the same cycle, `src_sof` wins.
- **Read side.**
  - At `h==0` with `rep==0`, `rd_bank` is loaded with `~wr_bank`, the last completed line.
  - Read address is `h >> log2(SCALE)` while `h<H_ACTIVE`.
  - `rd_bank` is held for all `SCALE` repeats of that line.
- **Active and sync.**
  - `de_raw = h<H_ACTIVE && v<V_ACTIVE`.
  - `hs` is active for `H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC`.
  - `vs` is active for `V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC`.
- **Mask.** When `overscan=1`, pixels with `h<OS_L`, `h>=H_ACTIVE-OS_R`, `v<OS_T` or `v>=V_ACTIVE-OS_B` output 0. `de` stays high for these pixels.
- **Colour.** Each channel is its 5-bit value, right-shifted by 1 when dimmed (see Configuration), then truncated to the top `OUT_W` bits. When `de` is low, `r`, `g` and `b` are 0.
- **Reset values.** The following values apply asynchronously on reset:
  - `h`, `v`, `rep`, `wr_addr`, `wr_bank`, `rd_bank` = 0.
  - `de`, `r`, `g`, `b`, `locked`, `ovf` = 0.
  - `hs = ~HS_POL`, `vs = ~VS_POL`.
  - Line-buffer contents are not reset.
- **Reset mid-operation.** Output goes to the blanked, inactive-sync state immediately; after release the raster restarts at `h=0`, `v=0`.

## Timing
- Counter-to-output latency is 2 cycles: 1 cycle for the registered RAM read and 1 cycle for the output register.
- `hs`, `vs`, `de` and the mask decision are delayed to match, so all outputs are coherent in the same cycle.
- Write-to-read: a line written completely before the `rep==0`, `h==0` edge is displayed on that output line group.
- `locked` and `ovf` update one cycle after the causing input.
- Unlocked free-run: without `src_sof` the raster runs at H_TOT×V_TOT indefinitely.

## Configuration
- `VIDEO_SCANLINE_EN` defined: when `scanlines=1` and `SCALE>1`, output lines with `rep==SCALE-1` have every channel halved before truncation.
- `VIDEO_SCANLINE_EN` undefined: the `scanlines` input is ignored, no dimming logic is built, and the port remains present.

## Structure
- Package `video_pkg` holds:
  - the `rgb555_t` typedef with B/G/R fields;
  - the default timing localparams (682×524 NTSC-doubled set);
  - a `dim555` function;
  - the `clog2`-based `SCALE_SH` constant.
- Sub-module `line_buf_2bank`: simple dual-port RAM of 2×`SRC_W`×15 bits, synchronous write, registered read, with bank as the address MSB. It maps to EBR/SPRAM.
- Top level contains the counters, the bank control and the output pipeline only.

## Test plan
- **Reset.** Hold `rst_n=0` for 5 cycles mid-line → `de=0`, `rgb=0`, `hs=1`, `vs=1` (POL=0), `locked=0`. Release → first `hs` assertion at `h=570`, observed at cycle 572.
- **Doubling.** Write a line with `src_pixel=i` for i=0..255, then `src_sol`. Output pixels 2i and 2i+1 on both repeat lines carry pixel i; `r=g=b` derive from bits of i.
- **Frame lock.** Pulse `src_sof` at free-run `h=300`, `v=100` → next cycle `h=0`, `v=0`, `locked=1`. `vs` asserts exactly at line 490.
- **Overflow.** 260 `src_valid` in one line → pixels 256..259 dropped, `ovf=1` and sticky. Subsequent lines display correctly.
- **Overscan and scanlines.** `overscan=1` → pixels h=0..19 and lines v=0..11 output 0 with `de=1`. With `VIDEO_SCANLINE_EN`, `scanlines=1` and `src_pixel=0x7FFF`, odd lines output `r=g=b=4'h7` and even lines `4'hF`.
- **Simultaneous events.** `src_sof` coinciding with `h=H_TOT-1`, `v=V_TOT-1` → counters go to 0 once, with no skipped or doubled line. `SCALE=1` build → 1:1 output with dimming inactive.
